// File: rtl/haze_brightness_comp.sv
`default_nettype none
// ============================================================================
// Module   : haze_brightness_comp
// Purpose  : Global brightness compensation for the dehazed video stream.
//            Each frame's mean luma is measured, and a clamped offset is
//            derived as TARGET_Y - mean. That offset is applied to the
//            R, G and B channels of the following frame.
// Ports    : clk, rst_n (async, active-low)
//            pre_frame_vsync/href/clken, pre_img[23:0]  - input video {R,G,B}
//            post_frame_vsync/href/clken, post_img[23:0] - corrected video,
//                                                         2 clk latency
//            cur_ofs[8:0]  - signed offset currently applied
//            stat_valid    - 1-clk pulse when a new offset is latched
// Revision : 1.0 - initial release
// ============================================================================
module haze_brightness_comp #(
   parameter int TARGET_Y = 110,
   parameter int MAX_OFS  = 48
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        pre_frame_vsync,
   input  logic        pre_frame_href,
   input  logic        pre_frame_clken,
   input  logic [23:0] pre_img,
   output logic        post_frame_vsync,
   output logic        post_frame_href,
   output logic        post_frame_clken,
   output logic [23:0] post_img,
   output logic [8:0]  cur_ofs,
   output logic        stat_valid
);

   localparam logic [1:0] c_st_idle   = 2'd0;
   localparam logic [1:0] c_st_accum  = 2'd1;
   localparam logic [1:0] c_st_divide = 2'd2;
   localparam logic [1:0] c_st_update = 2'd3;

   localparam logic signed [10:0] c_target  = 11'(TARGET_Y);
   localparam logic signed [10:0] c_max_ofs = 11'(MAX_OFS);

   logic [1:0]  r_state;
   logic        r_vs_prev;
   logic [8:0]  r_ofs, r_pend_ofs;
   logic [9:0]  r_s1_r, r_s1_g, r_s1_b;
   logic [1:0]  r_vs_d, r_hr_d, r_ce_d;
   logic [14:0] r_py_r;
   logic [15:0] r_py_g;
   logic [12:0] r_py_b;
   logic [7:0]  r_luma;
   logic [31:0] r_sum, r_dvd, r_quot;
   logic [23:0] r_cnt, r_rem;
   logic        r_flush, r_flush_cnt;
   logic [4:0]  r_div_cnt;

   logic        w_vs_rise, w_vs_fall, w_acc_en, w_ge;
   logic [8:0]  w_ofs_load, w_ofs_now, w_new_ofs;
   logic [9:0]  w_ofs_ext;
   logic [32:0] w_sum_add;
   logic [24:0] w_trial;
   logic [7:0]  w_mean;
   logic signed [10:0] w_diff;

   function automatic logic [7:0] sat8(input logic [9:0] v);
      if (v[9])      return 8'd0;     // negative
      else if (v[8]) return 8'd255;   // above 255
      else           return v[7:0];
   endfunction

   assign w_vs_rise = pre_frame_vsync & ~r_vs_prev;
   assign w_vs_fall = ~pre_frame_vsync & r_vs_prev;

   // An update coinciding with a frame start hands its fresh value straight
   // to the active offset; a pixel arriving on the vsync-rise cycle already
   // sees the new offset.
   assign w_ofs_load = (r_state == c_st_update) ? w_new_ofs : r_pend_ofs;
   assign w_ofs_now  = w_vs_rise ? w_ofs_load : r_ofs;
   assign w_ofs_ext  = {w_ofs_now[8], w_ofs_now};

   assign w_acc_en  = (r_state == c_st_accum) & r_ce_d[1] & r_vs_d[1];
   assign w_sum_add = {1'b0, r_sum} + 33'(r_luma);

   // Restoring divider step: remainder is always below the divisor,
   // so 24 bits plus the incoming dividend bit suffice.
   assign w_trial = {r_rem, r_dvd[31]};
   assign w_ge    = (w_trial >= {1'b0, r_cnt});

   assign w_mean = (|r_quot[31:8]) ? 8'd255 : r_quot[7:0];

   always_comb begin
      w_diff = c_target - $signed({3'b000, w_mean});
      if (w_diff > c_max_ofs)       w_new_ofs = 9'(c_max_ofs);
      else if (w_diff < -c_max_ofs) w_new_ofs = 9'(-c_max_ofs);
      else                          w_new_ofs = w_diff[8:0];
   end

   assign cur_ofs    = r_ofs;
   assign stat_valid = (r_state == c_st_update);
   assign post_frame_vsync = r_vs_d[1];
   assign post_frame_href  = r_hr_d[1];
   assign post_frame_clken = r_ce_d[1];

   // vsync history resets high so a frame already in progress at reset
   // release is not mistaken for a new frame (its statistics are partial).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vs_prev <= 1'b1;
         r_ofs     <= '0;
      end else begin
         r_vs_prev <= pre_frame_vsync;
         if (w_vs_rise) r_ofs <= w_ofs_load;
      end
   end

   // Correction data path and luma pipeline, both 2 stages
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_r   <= '0;
         r_s1_g   <= '0;
         r_s1_b   <= '0;
         post_img <= '0;
         r_vs_d   <= '0;
         r_hr_d   <= '0;
         r_ce_d   <= '0;
         r_py_r   <= '0;
         r_py_g   <= '0;
         r_py_b   <= '0;
         r_luma   <= '0;
      end else begin
         r_s1_r   <= {2'b00, pre_img[23:16]} + w_ofs_ext;
         r_s1_g   <= {2'b00, pre_img[15:8]}  + w_ofs_ext;
         r_s1_b   <= {2'b00, pre_img[7:0]}   + w_ofs_ext;
         post_img <= {sat8(r_s1_r), sat8(r_s1_g), sat8(r_s1_b)};
         r_vs_d   <= {r_vs_d[0], pre_frame_vsync};
         r_hr_d   <= {r_hr_d[0], pre_frame_href};
         r_ce_d   <= {r_ce_d[0], pre_frame_clken};
         r_py_r   <= 15'(pre_img[23:16]) * 15'd77;
         r_py_g   <= 16'(pre_img[15:8])  * 16'd150;
         r_py_b   <= 13'(pre_img[7:0])   * 13'd29;
         r_luma   <= 8'((16'(r_py_r) + r_py_g + 16'(r_py_b)) >> 8);
      end
   end

   // Statistics FSM: accumulate, flush, divide, publish
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= c_st_idle;
         r_sum       <= '0;
         r_cnt       <= '0;
         r_flush     <= 1'b0;
         r_flush_cnt <= 1'b0;
         r_dvd       <= '0;
         r_rem       <= '0;
         r_quot      <= '0;
         r_div_cnt   <= '0;
         r_pend_ofs  <= '0;
      end else begin
         case (r_state)
            c_st_idle: begin
               if (w_vs_rise) begin
                  r_state <= c_st_accum;
                  r_sum   <= '0;
                  r_cnt   <= '0;
                  r_flush <= 1'b0;
               end
            end
            c_st_accum: begin
               if (w_acc_en) begin
                  r_sum <= w_sum_add[32] ? '1 : w_sum_add[31:0];
                  if (!(&r_cnt)) r_cnt <= r_cnt + 24'd1;
               end
               // Two-cycle flush after vsync falls lets the last pixel
               // clear the luma pipeline before the count is judged.
               if (r_flush) begin
                  if (w_vs_rise) begin
                     r_sum   <= '0;
                     r_cnt   <= '0;
                     r_flush <= 1'b0;
                  end else if (r_flush_cnt) begin
                     r_flush <= 1'b0;
                     if (r_cnt == '0) begin
                        r_state <= c_st_idle;
                     end else begin
                        r_state   <= c_st_divide;
                        r_dvd     <= r_sum;
                        r_rem     <= '0;
                        r_quot    <= '0;
                        r_div_cnt <= '0;
                     end
                  end else begin
                     r_flush_cnt <= 1'b1;
                  end
               end else if (w_vs_fall) begin
                  r_flush     <= 1'b1;
                  r_flush_cnt <= 1'b0;
               end
            end
            c_st_divide: begin
               if (w_vs_rise) begin
                  r_state <= c_st_accum;
                  r_sum   <= '0;
                  r_cnt   <= '0;
                  r_flush <= 1'b0;
               end else begin
                  r_rem     <= w_ge ? 24'(w_trial - {1'b0, r_cnt}) : w_trial[23:0];
                  r_quot    <= {r_quot[30:0], w_ge};
                  r_dvd     <= {r_dvd[30:0], 1'b0};
                  r_div_cnt <= r_div_cnt + 5'd1;
                  if (r_div_cnt == 5'd31) r_state <= c_st_update;
               end
            end
            c_st_update: begin
               r_pend_ofs <= w_new_ofs;
               if (w_vs_rise) begin
                  r_state <= c_st_accum;
                  r_sum   <= '0;
                  r_cnt   <= '0;
                  r_flush <= 1'b0;
               end else begin
                  r_state <= c_st_idle;
               end
            end
            default: r_state <= c_st_idle;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_haze_brightness_comp.sv
`default_nettype none
// ============================================================================
// Module   : tb_haze_brightness_comp
// Purpose  : Self-checking bench for haze_brightness_comp (default params).
// Revision : 1.0 - initial release
// ============================================================================
module tb_haze_brightness_comp;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        pre_frame_vsync = 1'b0;
   logic        pre_frame_href = 1'b0;
   logic        pre_frame_clken = 1'b0;
   logic [23:0] pre_img = '0;
   logic        post_frame_vsync, post_frame_href, post_frame_clken;
   logic [23:0] post_img;
   logic [8:0]  cur_ofs;
   logic        stat_valid;

   int n_checks = 0;
   int n_fail   = 0;

   haze_brightness_comp #(.TARGET_Y(110), .MAX_OFS(48)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .pre_frame_vsync  (pre_frame_vsync),
      .pre_frame_href   (pre_frame_href),
      .pre_frame_clken  (pre_frame_clken),
      .pre_img          (pre_img),
      .post_frame_vsync (post_frame_vsync),
      .post_frame_href  (post_frame_href),
      .post_frame_clken (post_frame_clken),
      .post_img         (post_img),
      .cur_ofs          (cur_ofs),
      .stat_valid       (stat_valid)
   );

   always #5 clk = ~clk;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [23:0] a;     // stats frame, first half of pixels
      logic [23:0] b;     // stats frame, second half of pixels
      logic [8:0]  ofs;   // offset expected in the following frame
      logic [23:0] pix;   // test pixel in the following frame
      logic [23:0] exp;   // expected corrected pixel
   } vec_t;

   vec_t vecs[9];

   function automatic logic [23:0] gray(input logic [7:0] v);
      return {v, v, v};
   endfunction

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   // Single pixel inside an open frame, checked 2 clk later with strobes
   task automatic apply_pixel(input string name, input logic [23:0] pix, input logic [23:0] exp);
      pre_img = pix; pre_frame_href = 1'b1; pre_frame_clken = 1'b1;
      tick();
      pre_img = '0; pre_frame_href = 1'b0; pre_frame_clken = 1'b0;
      tick();
      check({name, "_img"}, {8'd0, post_img}, {8'd0, exp});
      check({name, "_strobes"}, {29'd0, post_frame_vsync, post_frame_href, post_frame_clken}, 32'd7);
      tick();
      check({name, "_clken_drop"}, {31'd0, post_frame_clken}, 32'd0);
   endtask

   task automatic drive_pixels(input logic [23:0] a, input logic [23:0] b, input int n);
      for (int i = 0; i < n; i++) begin
         pre_img = (i < n / 2) ? a : b;
         pre_frame_href = 1'b1; pre_frame_clken = 1'b1;
         tick();
      end
      pre_img = '0; pre_frame_href = 1'b0; pre_frame_clken = 1'b0;
      tick(); tick();
   endtask

   task automatic end_frame_expect_stat(input string name);
      logic [8:0] ofs_before;
      int k;
      ofs_before = cur_ofs;
      pre_frame_vsync = 1'b0;
      k = 0;
      while (k < 60 && !stat_valid) begin
         tick();
         k++;
      end
      n_checks++;
      if (!(stat_valid && k >= 34 && k <= 40)) begin
         n_fail++;
         $display("FAIL %s_stat_latency: got %0d clk (pulse=%0b), required 34..40 with pulse", name, k, stat_valid);
      end
      check({name, "_ofs_at_pulse"}, {23'd0, cur_ofs}, {23'd0, ofs_before});
      tick();
      check({name, "_pulse_width"}, {31'd0, stat_valid}, 32'd0);
   endtask

   task automatic end_frame_expect_none(input string name, input int cycles);
      logic seen;
      seen = 1'b0;
      pre_frame_vsync = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         tick();
         if (stat_valid) seen = 1'b1;
      end
      check({name, "_no_stat"}, {31'd0, seen}, 32'd0);
   endtask

   task automatic wait_cycles(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      vecs[0] = '{gray(60),  gray(60),  9'd48,       {8'd250, 8'd10, 8'd0},   {8'd255, 8'd58, 8'd48}};
      vecs[1] = '{gray(200), gray(200), 9'(-48),     gray(30),                gray(0)};
      vecs[2] = '{gray(80),  gray(120), 9'd10,       gray(100),               gray(110)};
      vecs[3] = '{gray(110), gray(110), 9'd0,        {8'd1, 8'd2, 8'd3},      {8'd1, 8'd2, 8'd3}};
      vecs[4] = '{{8'd255, 8'd0, 8'd0}, {8'd255, 8'd0, 8'd0}, 9'd34,
                  {8'd221, 8'd222, 8'd0}, {8'd255, 8'd255, 8'd34}};
      vecs[5] = '{gray(90),  gray(90),  9'd20,       {8'd240, 8'd5, 8'd235},  {8'd255, 8'd25, 8'd255}};
      vecs[6] = '{gray(100), gray(101), 9'd10,       gray(0),                 gray(10)};
      vecs[7] = '{gray(255), gray(255), 9'(-48),     {8'd40, 8'd100, 8'd255}, {8'd0, 8'd52, 8'd207}};
      vecs[8] = '{gray(63),  gray(63),  9'd47,       gray(0),                 gray(47)};

      // Reset state
      wait_cycles(3);
      check("reset_img", {8'd0, post_img}, 32'd0);
      check("reset_strobes", {29'd0, post_frame_vsync, post_frame_href, post_frame_clken}, 32'd0);
      check("reset_ofs", {23'd0, cur_ofs}, 32'd0);
      check("reset_stat", {31'd0, stat_valid}, 32'd0);
      rst_n = 1'b1;
      wait_cycles(3);

      // First frame passes unmodified, then the measured offset takes effect
      pre_frame_vsync = 1'b1; tick();
      check("f1_ofs", {23'd0, cur_ofs}, 32'd0);
      apply_pixel("f1_pix", gray(60), gray(60));
      end_frame_expect_stat("f1");
      wait_cycles(5);
      pre_frame_vsync = 1'b1; tick();
      check("f2_ofs", {23'd0, cur_ofs}, 32'd48);
      apply_pixel("f2_pix", gray(60), gray(108));
      pre_frame_vsync = 1'b0;
      wait_cycles(45);

      // Table: statistics frame then a test frame using the new offset
      for (int i = 0; i < 9; i++) begin
         pre_frame_vsync = 1'b1; tick();
         drive_pixels(vecs[i].a, vecs[i].b, 8);
         end_frame_expect_stat($sformatf("v%0d", i));
         wait_cycles(5);
         pre_frame_vsync = 1'b1; tick();
         check($sformatf("v%0d_ofs", i), {23'd0, cur_ofs}, {23'd0, vecs[i].ofs});
         apply_pixel($sformatf("v%0d_pix", i), vecs[i].pix, vecs[i].exp);
         pre_frame_vsync = 1'b0;
         wait_cycles(45);
      end

      // Short vertical blank aborts the division; the next frame's
      // statistics must start from cleared accumulators.
      pre_frame_vsync = 1'b1; tick();
      drive_pixels(gray(200), gray(200), 8);
      end_frame_expect_stat("pre_abort");
      wait_cycles(5);
      pre_frame_vsync = 1'b1; tick();
      check("abort_ofs_before", {23'd0, cur_ofs}, {23'd0, 9'(-48)});
      drive_pixels(gray(60), gray(60), 8);
      end_frame_expect_none("abort", 5);
      pre_frame_vsync = 1'b1; tick();
      check("abort_ofs_kept", {23'd0, cur_ofs}, {23'd0, 9'(-48)});
      drive_pixels(gray(90), gray(90), 8);
      end_frame_expect_stat("after_abort");
      wait_cycles(5);
      pre_frame_vsync = 1'b1; tick();
      check("after_abort_ofs", {23'd0, cur_ofs}, 32'd20);
      pre_frame_vsync = 1'b0;
      wait_cycles(5);

      // Frame with no valid pixels yields no update
      pre_frame_vsync = 1'b1;
      wait_cycles(4);
      end_frame_expect_none("empty", 50);
      pre_frame_vsync = 1'b1; tick();
      check("empty_ofs_kept", {23'd0, cur_ofs}, 32'd20);

      // Reset mid-frame with pixels in flight
      pre_img = gray(200); pre_frame_href = 1'b1; pre_frame_clken = 1'b1;
      wait_cycles(3);
      rst_n = 1'b0;
      #1;
      check("midrst_img", {8'd0, post_img}, 32'd0);
      check("midrst_strobes", {29'd0, post_frame_vsync, post_frame_href, post_frame_clken}, 32'd0);
      check("midrst_ofs", {23'd0, cur_ofs}, 32'd0);
      check("midrst_stat", {31'd0, stat_valid}, 32'd0);
      wait_cycles(3);
      rst_n = 1'b1;
      drive_pixels(gray(200), gray(200), 4);
      end_frame_expect_none("midrst_partial", 50);
      pre_frame_vsync = 1'b1; tick();
      check("postrst_ofs", {23'd0, cur_ofs}, 32'd0);
      apply_pixel("postrst_pix", {8'd77, 8'd88, 8'd99}, {8'd77, 8'd88, 8'd99});
      pre_frame_vsync = 1'b0;
      wait_cycles(10);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/haze_brightness_comp.md
HAZE_BRIGHTNESS_COMP -- requirements
Module: haze_brightness_comp

Interface
REQ-001 SHALL have parameter TARGET_Y, default 110: target mean luma, 0..255.
REQ-002 SHALL have parameter MAX_OFS, default 48: magnitude limit for the applied offset, 0..127.
REQ-003 SHALL have port clk, input, 1: single clock for all logic.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port pre_frame_vsync, input, 1: high for the whole active frame.
REQ-006 SHALL have port pre_frame_href, input, 1: line-active qualifier.
REQ-007 SHALL have port pre_frame_clken, input, 1: pixel valid.
REQ-008 SHALL have port pre_img, input, 24: pixel as {R,G,B}, 8 bits each; this is the dehazed output of haze_remove_top.
REQ-009 SHALL have ports post_frame_vsync, post_frame_href and post_frame_clken, output, 1 each: delayed copies of the pre_* strobes.
REQ-010 SHALL have port post_img, output, 24: offset-corrected pixel as {R,G,B}.
REQ-011 SHALL have port cur_ofs, output, 9: signed two's-complement offset currently applied.
REQ-012 SHALL have port stat_valid, output, 1: one-cycle pulse when a new offset is latched.

Function
REQ-013 Data path latency SHALL be exactly 2 clk.
- All three post_* strobes are delayed 2 clk with no gating.
REQ-014 Data path stage 1 SHALL compute the 10-bit signed sums R+ofs, G+ofs and B+ofs, where ofs is the active offset.
REQ-015 Data path stage 2 SHALL saturate each channel to 0..255 and register it to post_img.
REQ-016 Statistics SHALL compute luma on input pixels (pre-correction) as Y=(77R+150G+29B)>>8, pipelined in 2 stages.
REQ-017 SHALL accumulate Y into a 32-bit sum and count pixels in a 24-bit counter.
- Both accumulate only when the pipelined clken and vsync are both high.
- The sum saturates at 2^32-1; the counter saturates at 2^24-1.
REQ-018 SHALL implement FSM states IDLE, ACCUM, DIVIDE, UPDATE.
REQ-019 IDLE->ACCUM SHALL occur on a rising edge of pre_frame_vsync.
- Entering ACCUM clears the sum and the count.
REQ-020 ACCUM->DIVIDE SHALL occur 2 clk after a falling edge of pre_frame_vsync, so the last pixel in the pipeline is flushed.
- If count==0 the transition SHALL instead be ACCUM->IDLE, with no update.
REQ-021 DIVIDE SHALL run a sequential restoring divider, mean=sum/count, taking exactly 32 clk, one quotient bit per clk.
- The quotient saturates to 255 if it exceeds 255.
REQ-022 If pre_frame_vsync rises while in DIVIDE, the division SHALL be aborted.
- The offset is unchanged and the state goes directly to ACCUM with the accumulators cleared.
REQ-023 UPDATE SHALL last 1 clk and then return to IDLE.
- It latches pend_ofs = clamp(TARGET_Y - mean, -MAX_OFS, +MAX_OFS).
- It pulses stat_valid for that clk.
REQ-024 The active offset SHALL load from pend_ofs only on a rising edge of pre_frame_vsync.
- The offset is therefore constant within a frame, and the first frame after a statistics update uses the new value.
REQ-025 cur_ofs SHALL show the active offset.
REQ-026 Simultaneous UPDATE and vsync rise SHALL load the newly latched pend_ofs.

Reset
REQ-027 On rst_n low, all of the following SHALL clear asynchronously:
- all post_* outputs to 0;
- cur_ofs, pend_ofs and stat_valid to 0;
- sum and count to 0;
- the FSM to IDLE.
REQ-028 After reset release the first frame SHALL pass with offset 0.
- Reset asserted mid-frame discards partial statistics.

Verification
REQ-029 Frame 1 uniform (60,60,60), defaults -> stat_valid pulses 34+ clk after vsync fall with cur_ofs unchanged (0); frame 2 input (60,60,60) -> post_img (108,108,108), cur_ofs=+48.
REQ-030 With offset +48, pixel (250,10,0) -> (255,58,48) exactly 2 clk later, strobes aligned.
REQ-031 Uniform frame (200,200,200) -> next frame offset -48; pixel (30,30,30) -> (0,0,0).
REQ-032 Frame mean 100 (half pixels 80, half 120 gray) -> offset +10; pixel (100,100,100) -> (110,110,110).
REQ-033 vsync rises 5 clk after a fall -> no stat_valid, cur_ofs retained, new statistics collected correctly.
REQ-034 vsync pulse with no clken -> no stat_valid; rst_n pulsed mid-frame -> all outputs 0 and offset 0 on the next frame.
